// File: rtl/vx_ag_tcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_ag_tcu_pkg
// Brief    : Shared types, format codes and helpers for the TCU tile sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vx_ag_tcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } tcu_state_e;

  localparam logic [2:0] FMT_FP16 = 3'd1;
  localparam logic [2:0] FMT_BF16 = 3'd2;

  function automatic logic tcu_fmt_valid(input logic [2:0] fmt);
    return (fmt == FMT_FP16) || (fmt == FMT_BF16);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vx_ag_tcu_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vx_ag_tcu_tag_pipe
// Brief    : Enabled valid+index delay line that shadows the FEDP pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module vx_ag_tcu_tag_pipe #(
  parameter int DEPTH = 16,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_vld,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_vld,
  output logic [IDXW-1:0] out_idx
);

  logic [DEPTH-1:0]           r_vld;
  logic [DEPTH-1:0][IDXW-1:0] r_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_idx <= '0;
    end else if (enable) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        r_vld[s] <= r_vld[s-1];
        r_idx[s] <= r_idx[s-1];
      end
      r_vld[0] <= in_vld;
      r_idx[0] <= in_idx;
    end
  end

  assign out_vld = r_vld[DEPTH-1];
  assign out_idx = r_idx[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vx_ag_tcu_fedp_seq.sv
`default_nettype none
// ============================================================================
// Module   : vx_ag_tcu_fedp_seq
// Brief    : Issues one tile of dot products row-major to the FEDP and
//            gathers the tagged results into a tile returned via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module vx_ag_tcu_fedp_seq
  import vx_ag_tcu_pkg::*;
#(
  parameter int N       = 4,
  parameter int TILE_M  = 4,
  parameter int TILE_N  = 4,
  parameter int LATENCY = 16,
  parameter int XLEN    = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_fmt_s,
  input  logic [2:0]                     req_fmt_d,
  input  logic [TILE_M*N*XLEN-1:0]       req_a,
  input  logic [TILE_N*N*XLEN-1:0]       req_b,
  input  logic [TILE_M*TILE_N*XLEN-1:0]  req_c,
  output logic                           fedp_enable,
  output logic [2:0]                     fedp_fmt_s,
  output logic [2:0]                     fedp_fmt_d,
  output logic [N*XLEN-1:0]              fedp_a_row,
  output logic [N*XLEN-1:0]              fedp_b_col,
  output logic [XLEN-1:0]                fedp_c_val,
  input  logic [XLEN-1:0]                fedp_d_val,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [TILE_M*TILE_N*XLEN-1:0]  rsp_d,
  output logic                           rsp_err
);

  localparam int T     = TILE_M * TILE_N;
  localparam int IDXW  = (T > 1) ? $clog2(T) : 1;
  localparam int ROW_W = N * XLEN;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(T - 1);
  localparam logic [IDXW-1:0] LAST_COL = IDXW'(TILE_N - 1);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("LATENCY must be at least 1");
    end
    if (T < 2) begin : g_bad_tile
      $error("TILE_M*TILE_N must be at least 2");
    end
  endgenerate

  tcu_state_e                  r_state, w_state_n;
  logic [IDXW-1:0]             r_cnt, r_row, r_col;
  logic [TILE_M*N*XLEN-1:0]    r_a;
  logic [TILE_N*N*XLEN-1:0]    r_b;
  logic [T*XLEN-1:0]           r_c;
  logic [T*XLEN-1:0]           r_d;
  logic [2:0]                  r_fmt_s, r_fmt_d;
  logic                        r_err;
  logic                        w_fedp_en, w_push, w_tag_vld;
  logic [IDXW-1:0]             w_tag_idx;
  logic                        w_issue;

  vx_ag_tcu_tag_pipe #(
    .DEPTH (LATENCY),
    .IDXW  (IDXW)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .enable  (w_fedp_en),
    .in_vld  (w_push),
    .in_idx  (r_cnt),
    .out_vld (w_tag_vld),
    .out_idx (w_tag_idx)
  );

  always_comb begin
    w_state_n = r_state;
    w_fedp_en = 1'b0;
    w_push    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && req_ready) w_state_n = ISSUE;
      end
      ISSUE: begin
        w_fedp_en = 1'b1;
        w_push    = 1'b1;
        if (r_cnt == LAST_IDX) w_state_n = DRAIN;
      end
      DRAIN: begin
        w_fedp_en = 1'b1;
        if (w_tag_vld && (w_tag_idx == LAST_IDX)) w_state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_fmt_s <= '0;
      r_fmt_d <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if ((r_state == IDLE) && req_valid) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_c     <= req_c;
        r_fmt_s <= req_fmt_s;
        r_fmt_d <= req_fmt_d;
        r_err   <= !tcu_fmt_valid(req_fmt_s);
        r_cnt   <= '0;
        r_row   <= '0;
        r_col   <= '0;
      end else if (r_state == ISSUE) begin
        r_cnt <= r_cnt + IDXW'(1);
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + IDXW'(1);
        end else begin
          r_col <= r_col + IDXW'(1);
        end
      end
      // Results of an unsupported format are suppressed rather than stored.
      if (w_tag_vld) r_d[w_tag_idx*XLEN +: XLEN] <= r_err ? '0 : fedp_d_val;
    end
  end

  assign w_issue     = (r_state == ISSUE);
  assign req_ready   = (r_state == IDLE) && reset;
  assign fedp_enable = w_fedp_en;
  assign fedp_fmt_s  = r_fmt_s;
  assign fedp_fmt_d  = r_fmt_d;
  assign fedp_a_row  = w_issue ? r_a[r_row*ROW_W +: ROW_W] : '0;
  assign fedp_b_col  = w_issue ? r_b[r_col*ROW_W +: ROW_W] : '0;
  assign fedp_c_val  = w_issue ? r_c[r_cnt*XLEN +: XLEN]   : '0;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_err     = (r_state == RESP) && r_err;
  assign rsp_d       = r_d;

endmodule
`default_nettype wire

// File: tb/tb_vx_ag_tcu_fedp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_ag_tcu_fedp_seq
// Brief    : Bench for the TCU tile sequencer with a behavioural FEDP model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_ag_tcu_fedp_seq;

  localparam int NW  = 4;
  localparam int TM  = 4;
  localparam int TN  = 4;
  localparam int LAT = 16;
  localparam int T   = TM * TN;
  localparam int TW  = T * 32;

  logic              clk, reset;
  logic              req_valid, req_ready;
  logic [2:0]        req_fmt_s, req_fmt_d;
  logic [TM*NW*32-1:0] req_a;
  logic [TN*NW*32-1:0] req_b;
  logic [TW-1:0]     req_c;
  logic              fedp_enable;
  logic [2:0]        fedp_fmt_s, fedp_fmt_d;
  logic [NW*32-1:0]  fedp_a_row, fedp_b_col;
  logic [31:0]       fedp_c_val, fedp_d_val;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [TW-1:0]     rsp_d;

  vx_ag_tcu_fedp_seq #(.N(NW), .TILE_M(TM), .TILE_N(TN), .LATENCY(LAT), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val),
    .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d(rsp_d), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v << (23 - e));
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  // Behavioural FEDP: only exact 1.0*1.0 lane products contribute.
  function automatic logic [31:0] fedp_model(input logic [2:0] fs, input logic [NW*32-1:0] a,
                                             input logic [NW*32-1:0] b, input logic [31:0] c);
    logic [15:0] one;
    int cnt;
    one = (fs == 3'd2) ? 16'h3F80 : 16'h3C00;
    cnt = 0;
    for (int l = 0; l < 2 * NW; l++)
      if (a[l*16 +: 16] == one && b[l*16 +: 16] == one) cnt++;
    return i2f(f2i(c) + cnt);
  endfunction

  logic [31:0] fp_pipe [LAT];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fedp_enable) begin
      for (int s = LAT - 1; s > 0; s--) fp_pipe[s] <= fp_pipe[s-1];
      fp_pipe[0] <= fedp_model(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
    end
  end
  assign fedp_d_val = fp_pipe[LAT-1];

  function automatic logic [TW-1:0] fill(input logic [31:0] w);
    logic [TW-1:0] v;
    for (int i = 0; i < T; i++) v[i*32 +: 32] = w;
    return v;
  endfunction

  typedef struct {
    logic [TW-1:0] d;
    logic          err;
    int            acc;
  } exp_t;
  exp_t sb[$];

  // Response monitor: latency, tile contents, error flag and backpressure hold.
  logic          prev_v = 1'b0;
  logic          hs_prev = 1'b0;
  int            rise_cyc = 0;
  logic [TW-1:0] snap;
  exp_t          cur;
  always @(negedge clk) begin
    if (!reset) begin
      prev_v  = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("req_ready_after_rsp", req_ready, 1);
      hs_prev = 1'b0;
      if (rsp_valid && !prev_v) begin
        rise_cyc = cyc;
        snap     = rsp_d;
      end
      if (rsp_valid && !rsp_ready) begin
        chk("stall_rsp_d_stable", rsp_d == snap, 1);
        chk("stall_req_ready", req_ready, 0);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_latency", rise_cyc - cur.acc + 1, 33);
          chk("rsp_err", rsp_err, cur.err);
          for (int i = 0; i < T; i++)
            chk($sformatf("rsp_d[%0d]", i), rsp_d[i*32 +: 32], cur.d[i*32 +: 32]);
        end
        hs_prev = 1'b1;
      end
      prev_v = rsp_valid;
    end
  end

  // Called at a negedge; returns at the negedge following acceptance with req_valid still high.
  task automatic send(input logic [2:0] fs, input logic [TW-1:0] a, input logic [TW-1:0] b,
                      input logic [TW-1:0] c, input logic [TW-1:0] exp_d, input logic exp_err,
                      output int acc);
    exp_t e;
    bit ok;
    ok = 0;
    acc = 0;
    req_fmt_s = fs;
    req_fmt_d = 3'd5;
    req_a = a;
    req_b = b;
    req_c = c;
    req_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (req_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      acc = cyc;
      e.d = exp_d;
      e.err = exp_err;
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  logic [TW-1:0] ones, zeros, ramp, nine;
  int acc0, acc1;

  initial begin
    ones  = fill(32'h3C00_3C00);
    zeros = '0;
    nine  = fill(32'h4110_0000);
    for (int i = 0; i < T; i++) ramp[i*32 +: 32] = i2f(i);

    reset = 1'b0;
    req_valid = 1'b0;
    req_fmt_s = '0;
    req_fmt_d = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fedp_enable", fedp_enable, 0);
    chk("rst_rsp_d", |rsp_d, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_fedp_a_row", |fedp_a_row, 0);

    // fp16 all-ones tile
    send(3'd1, ones, ones, fill(32'h3F80_0000), nine, 1'b0, acc0);
    req_valid = 1'b0;
    chk("issue_fedp_enable", fedp_enable, 1);
    chk("issue_fmt_d", fedp_fmt_d, 3'd5);
    wait_done();

    // bf16 ordering
    send(3'd2, zeros, zeros, ramp, ramp, 1'b0, acc0);
    req_valid = 1'b0;
    wait_done();

    // backpressure
    rsp_ready = 1'b0;
    send(3'd2, zeros, zeros, ramp, ramp, 1'b0, acc0);
    req_valid = 1'b0;
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    chk("bp_rsp_valid", rsp_valid, 1);
    repeat (10) @(negedge clk);
    rsp_ready = 1'b1;
    wait_done();

    // unsupported format
    send(3'd3, ones, ones, fill(32'h3F80_0000), zeros, 1'b1, acc0);
    req_valid = 1'b0;
    wait_done();

    // reset during ISSUE at element 5
    send(3'd2, zeros, zeros, ramp, ramp, 1'b0, acc0);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_issue_c_val", fedp_c_val, 32'h40A0_0000);
    reset = 1'b0;
    #1;
    chk("mid_rst_fedp_enable", fedp_enable, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_c_val", fedp_c_val, 0);
    chk("mid_rst_rsp_d", |rsp_d, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(3'd1, ones, ones, fill(32'h3F80_0000), nine, 1'b0, acc0);
    req_valid = 1'b0;
    wait_done();

    // back-to-back
    send(3'd1, ones, ones, fill(32'h3F80_0000), nine, 1'b0, acc0);
    send(3'd2, zeros, zeros, ramp, ramp, 1'b0, acc1);
    req_valid = 1'b0;
    chk("b2b_gap", acc1 - rise_cyc, 2);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
